conv_encoder_tx: RTL and testbench
==================================

// Module: conv_encoder_tx
// PURPOSE
//  Rate-1/2 convolutional encoder: the transmit-side counterpart of the Viterbi decoder.
//  Accepts bytes over valid/ready and serialises them MSB-first. Emits one 2-bit code
//  symbol per input bit, plus a soft-mapped copy in the decoder's rxsig format.
//  Terminates each frame with K-1 zero tail bits so the decoder ends in state 0.
//  Drives the decoder in loopback benches and on-board self-test.
// PARAMETERS
//  K       7       constraint length (state register is K-1 bits)
//  G0      7'o171  generator polynomial for c0 (MSB taps current input bit)
//  G1      7'o133  generator polynomial for c1
//  SOFT_W  3       bits per soft symbol; 2*SOFT_W = decoder rxsig width (6)
// PORTS
//  clk        in   1         system clock (100 MHz)
//  rst        in   1         synchronous reset, active-high
//  in_valid   in   1         in_data/in_last valid
//  in_ready   out  1         byte accepted when in_valid & in_ready
//  in_data    in   8         payload byte, bit 7 encoded first
//  in_last    in   1         byte is last of frame; tail follows it
//  out_valid  out  1         out_sym/out_soft/out_last valid
//  out_ready  in   1         symbol consumed when out_valid & out_ready
//  out_sym    out  2         {c0,c1} hard code bits
//  out_soft   out  2*SOFT_W  {soft(c0),soft(c1)}, two's complement
//  out_last   out  1         high on final tail symbol of frame
// BEHAVIOUR
//  - One clock domain. All regs reset synchronously on rst=1:
//    state=IDLE, sr=0, bit_cnt=0, out_valid=0, out_last=0. in_ready=1 in IDLE.
//  - FSM states:
//    IDLE: in_ready=1; handshake loads byte/last flag, bit_cnt=0 -> DATA.
//    DATA: current bit u=byte[7-bit_cnt]. On out handshake: shift sr, bit_cnt++.
//      bit_cnt==7 handshake: if last flag -> TAIL (tail_cnt=0).
//      Otherwise, if in_valid, load next byte and stay in DATA; else -> IDLE.
//    TAIL: u=0. On each out handshake shift sr. After K-1 handshakes -> IDLE.
//      sr is then 0 by construction.
//  - in_ready=1 in IDLE. In DATA it is 1 only when bit_cnt==7 & out_ready &
//    !last_flag (combinational from out_ready). It is 0 in TAIL; in_valid there is ignored.
//  - Encoding: w = {u, sr[K-2:0]}, sr[K-2] = most recent previous bit.
//    c0 = ^(w & G0), c1 = ^(w & G1). On handshake: sr <= {u, sr[K-2:1]}.
//  - out_valid=1 in DATA and TAIL, 0 in IDLE. Registered; first symbol appears
//    the cycle after the byte handshake (latency 1).
//  - out_sym/out_soft are combinational from registers only. They hold stable while
//    out_valid & !out_ready; no out_ready->output combinational path.
//  - Soft map per bit: 0 -> +(2^(SOFT_W-1)-1), 1 -> -(2^(SOFT_W-1)-1).
//    SOFT_W=3 gives 0 -> 3'b011 and 1 -> 3'b101.
//  - out_last = (state==TAIL) & (tail_cnt==K-2).
//  - Frame length = 8*N + K-1 symbols. Back-to-back bytes give no bubble.
//  - Reset mid-frame: frame is abandoned, no tail is emitted, next frame starts from sr=0.
//  - If rst and a handshake occur in the same cycle, rst wins.
// TESTING
//  1 Byte 0x80, in_last=1, out_ready=1 -> 14 symbols, the impulse response:
//    11,10,11,11,00,01,11, then 7x 00; out_last only on the 14th.
//  2 Byte 0x00 last -> 14 symbols of 00, out_soft=6'b011_011 each; sr=0 at end.
//  3 Bytes 0xA5, 0x3C (last), out_ready=1, in_valid held -> 22 symbols in 22
//    consecutive cycles, no gap. Must match golden model (Python/C) bit-exact.
//  4 Same as 3 with out_ready toggled pseudo-randomly -> identical symbol sequence.
//    Outputs stable on every stalled cycle.
//  5 Assert rst for 1 cycle after 5 symbols of a frame -> next cycle out_valid=0 and
//    in_ready=1. A following 0x80 last frame reproduces test 1 exactly.
//  6 in_valid=1 during TAIL -> in_ready=0, byte not consumed. It is accepted in the
//    first IDLE cycle after out_last.

Source files
------------

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder (K=7, 171/133), MSB-first byte serialiser
// with hard {c0,c1} and soft-mapped symbols plus a K-1 zero tail per frame.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        byte handshake; in_data payload, in_last ends frame
//   out_valid/out_ready      symbol handshake
//   out_sym                  {c0,c1} hard code bits
//   out_soft                 {soft(c0),soft(c1)}, two's complement
//   out_last                 final tail symbol of the frame
module conv_encoder_tx #(
    parameter int              K      = 7,
    parameter logic [K-1:0]    G0     = 7'o171,
    parameter logic [K-1:0]    G1     = 7'o133,
    parameter int              SOFT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_sym,
    output logic [2*SOFT_W-1:0]   out_soft,
    output logic                  out_last
);

    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] TAIL_END = CW'(K - 2);

    localparam int SOFT_MAG = 2 ** (SOFT_W - 1) - 1;
    localparam logic [SOFT_W-1:0] SOFT_POS = SOFT_W'(SOFT_MAG);
    localparam logic [SOFT_W-1:0] SOFT_NEG = SOFT_W'(-SOFT_MAG);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [K-2:0]  sr_q, sr_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] tail_cnt_q, tail_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;

    logic          u;
    logic [K-1:0]  w;
    logic          c0, c1;
    logic          out_hs;

    // Tail and idle both feed zeros into the encoder.
    assign u = (state_q == S_DATA) ? byte_q[3'd7 - bit_cnt_q] : 1'b0;

    // sr[K-2] holds the most recent previous bit.
    assign w  = {u, sr_q};
    assign c0 = ^(w & G0);
    assign c1 = ^(w & G1);

    assign out_valid = (state_q != S_IDLE);
    assign out_last  = (state_q == S_TAIL) && (tail_cnt_q == TAIL_END);
    assign out_sym   = {c0, c1};
    assign out_soft  = {c0 ? SOFT_NEG : SOFT_POS,
                        c1 ? SOFT_NEG : SOFT_POS};
    assign out_hs    = out_valid & out_ready;

    // Next byte may be taken on the last data bit so consecutive
    // bytes of a frame stream without a bubble.
    assign in_ready = (state_q == S_IDLE) ||
                      ((state_q == S_DATA) && (bit_cnt_q == 3'd7) &&
                       out_ready && !last_q);

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        byte_d     = byte_q;
        last_d     = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    byte_d    = in_data;
                    last_d    = in_last;
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (out_hs) begin
                    sr_d      = {u, sr_q[K-2:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (last_q) begin
                            state_d    = S_TAIL;
                            tail_cnt_d = '0;
                        end else if (in_valid) begin
                            byte_d = in_data;
                            last_d = in_last;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (out_hs) begin
                    sr_d       = {u, sr_q[K-2:1]};
                    tail_cnt_d = tail_cnt_q + CW'(1);
                    if (tail_cnt_q == TAIL_END) begin
                        state_d    = S_IDLE;
                        tail_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= 3'd0;
            tail_cnt_q <= '0;
            byte_q     <= 8'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Scoreboard bench for conv_encoder_tx: directed frames, expected
// symbols queued at issue time, monitor pops on each output handshake.
module tb_conv_encoder_tx;

    localparam logic [6:0] G0 = 7'o171;
    localparam logic [6:0] G1 = 7'o133;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic [5:0] out_soft;
    logic       out_last;

    always #5 clk = ~clk;

    conv_encoder_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_soft  (out_soft),
        .out_last  (out_last)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode = 0;

    logic [2:0] exp_q[$];

    // Impulse response of 171/133 followed by seven zero symbols.
    logic [1:0] IMP [14] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01,
                             2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                             2'b00, 2'b00};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    function automatic logic [5:0] soft_of(input logic [1:0] s);
        return {s[1] ? 3'b101 : 3'b011, s[0] ? 3'b101 : 3'b011};
    endfunction

    // Monitor
    logic       stall_v = 1'b0;
    logic [8:0] stall_val;
    bit         mon_start = 1'b1;
    int         first_cyc = 0;
    int         last_cyc  = 0;

    always @(negedge clk) begin
        logic [2:0] e;
        if (stall_v && out_valid) begin
            total++;
            if ({out_sym, out_soft, out_last} !== stall_val) begin
                bad++;
                $display("FAIL stall_hold got=%b want=%b",
                         {out_sym, out_soft, out_last}, stall_val);
            end
        end
        stall_v = out_valid && !out_ready;
        if (stall_v) stall_val = {out_sym, out_soft, out_last};
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_sym got=%b", out_sym);
            end else begin
                e = exp_q.pop_front();
                if ({out_sym, out_last} !== e ||
                    out_soft !== soft_of(e[2:1])) begin
                    bad++;
                    $display("FAIL sym got=%b/%b/%b want=%b/%b/%b",
                             out_sym, out_soft, out_last,
                             e[2:1], soft_of(e[2:1]), e[0]);
                end
            end
            if (mon_start) begin
                first_cyc = cyc;
                mon_start = 1'b0;
            end
            if (out_last) begin
                last_cyc  = cyc;
                mon_start = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic push_impulse();
        for (int i = 0; i < 14; i++) exp_q.push_back({IMP[i], i == 13});
    endtask

    task automatic push_zero_frame();
        for (int i = 0; i < 14; i++) exp_q.push_back({2'b00, i == 13});
    endtask

    // Reference encoder written as a convolution over the bit history.
    task automatic push_model(input logic [7:0] bs [4], input int n);
        logic h[$];
        int   ns;
        logic c0, c1;
        for (int b = 0; b < n; b++)
            for (int k = 7; k >= 0; k--) h.push_back(bs[b][k]);
        for (int k = 0; k < 6; k++) h.push_back(1'b0);
        ns = h.size();
        for (int t = 0; t < ns; t++) begin
            c0 = 1'b0;
            c1 = 1'b0;
            for (int i = 0; i < 7; i++) begin
                if (t - i >= 0) begin
                    c0 ^= G0[6-i] & h[t-i];
                    c1 ^= G1[6-i] & h[t-i];
                end
            end
            exp_q.push_back({c0, c1, t == ns - 1});
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l,
                             output int acc);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        acc      = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL in_timeout byte=%h accepted=0 want=1", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, acc2, n;
        logic [7:0] bs [4];
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_last", int'(out_last), 0);
        @(posedge clk);
        #1;

        // 1: impulse
        push_impulse();
        send_byte(8'h80, 1'b1, acc);
        in_valid = 1'b0;
        drain(100);
        chk("latency", first_cyc, acc + 1);

        // 2: all-zero frame
        push_zero_frame();
        send_byte(8'h00, 1'b1, acc);
        in_valid = 1'b0;
        drain(100);
        chk("sr_zero_end", int'(dut.sr_q), 0);

        // 3: two bytes back to back
        bs = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        push_model(bs, 2);
        send_byte(8'hA5, 1'b0, acc);
        send_byte(8'h3C, 1'b1, acc);
        in_valid = 1'b0;
        drain(100);
        chk("no_gap_span", last_cyc - first_cyc, 21);

        // 4: same with random backpressure
        rdy_mode = 1;
        push_model(bs, 2);
        send_byte(8'hA5, 1'b0, acc);
        send_byte(8'h3C, 1'b1, acc);
        in_valid = 1'b0;
        drain(500);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // 5: reset after five symbols
        for (int i = 0; i < 5; i++) exp_q.push_back({IMP[i], 1'b0});
        send_byte(8'h80, 1'b1, acc);
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
            if (n == 5) break;
        end
        chk("pre_rst_syms", n, 5);
        rdy_mode = 2;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mon_start = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_sr", int'(dut.sr_q), 0);
        chk("mid_rst_queue", exp_q.size(), 0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        push_impulse();
        send_byte(8'h80, 1'b1, acc);
        in_valid = 1'b0;
        drain(100);

        // 6: byte offered during tail waits for IDLE
        push_impulse();
        push_zero_frame();
        send_byte(8'h80, 1'b1, acc);
        send_byte(8'h00, 1'b1, acc2);
        in_valid = 1'b0;
        chk("tail_hold_accept", acc2, last_cyc + 1);
        drain(100);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
